single_base2_pow: RTL
=====================

SINGLE_BASE2_POW -- requirements
Module: single_base2_pow

Interface
REQ-001 SHALL have no parameters; the format is fixed to IEEE-754 single (bias 127, 23-bit fraction).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1 bit: operand a is valid this cycle.
REQ-005 SHALL have port a, input, 32 bits: operand x, single precision.
REQ-006 SHALL have port out_valid, output, 1 bit: c, overflow and underflow are valid this cycle.
REQ-007 SHALL have port c, output, 32 bits: 2^x, single precision.
REQ-008 SHALL have port overflow, output, 1 bit: result saturated to +Inf.
REQ-009 SHALL have port underflow, output, 1 bit: result flushed to +0.

Function
REQ-010 SHALL be a 3-stage pipeline with no backpressure; an operand is accepted every cycle in_valid=1.
REQ-011 SHALL assert out_valid exactly 3 rising edges after in_valid is sampled high.
REQ-012 SHALL deliver results in input order.
REQ-013 SHALL hold c, overflow and underflow at their last values while out_valid=0.
REQ-014 Stage 1 SHALL classify the operand:
  - NaN -> c=0x7FC00000.
  - +Inf -> c=0x7F800000 with overflow=1.
  - -Inf -> c=0x00000000 with underflow=1.
  - Zero or denormal (exponent field 0) -> x is treated as 0.
REQ-015 Stage 1 SHALL convert |x| to unsigned Q8.23, truncating fraction bits below 2^-23.
REQ-016 Stage 1 SHALL flag overflow when x>=128 and underflow when x<-126; these flags are evaluated before any truncation.
REQ-017 If sign=1, stage 1 SHALL form X = -|x| as signed two's-complement Q9.23.
REQ-018 Stage 1 SHALL take n = X[31:23] (signed floor of x) and f = X[22:0].
REQ-019 Stage 2 SHALL compute the mantissa by linear interpolation:
  - k = f[22:18], r = f[17:0].
  - m = T[k] + (((T[k+1]-T[k]) * r) >> 18), truncated to 23 bits.
  - T[j] = round(2^(j/32) * 2^23) - 2^23 for j=0..32, with T[32]=2^23.
  - m never exceeds 23 bits.
REQ-020 Stage 3 SHALL assemble c = {1'b0, n+127, m}.
REQ-021 If n+127 >= 255, stage 3 SHALL output c=0x7F800000 with overflow=1.
REQ-022 If n+127 <= 0, stage 3 SHALL output c=0x00000000 with underflow=1; no denormal results are produced.
REQ-023 overflow and underflow SHALL never both be 1.
REQ-024 Both flags SHALL be 0 for NaN and for in-range results.
REQ-025 For integer x in [-126,127], the result SHALL be exact: c = {0, x+127, 23'b0}.
REQ-026 The sign of c SHALL always be 0, except that NaN passes through as the canonical quiet NaN.

Reset
REQ-027 Assertion of reset_n=0 SHALL immediately clear out_valid, overflow, underflow, c (to 0) and all stage valid bits.
REQ-028 Operands in flight when reset is asserted SHALL be discarded; no out_valid pulse appears for them after release.
REQ-029 After reset_n returns to 1, the first in_valid SHALL produce out_valid 3 cycles later.
REQ-030 Datapath registers other than outputs need no reset.

Structure
REQ-031 Package single_pkg SHALL hold:
  - constants SINGLE_BIAS=127, SINGLE_QNAN=32'h7FC00000, SINGLE_PINF=32'h7F800000;
  - the 33-entry table T as a constant array.
REQ-032 The float-to-Q9.23 conversion with class/overflow/underflow detection (stage 1) SHALL be a sub-module named single_to_fixed.
REQ-033 Stages 2 and 3 SHALL reside in single_base2_pow.

Verification
REQ-034 The bench SHALL check: a=0x40400000 (3.0) -> c=0x41000000, flags 0, out_valid exactly 3 cycles after in_valid.
REQ-035 The bench SHALL check: a=0xC0000000 (-2.0) -> c=0x3E800000; a=0x3F000000 (0.5) -> c=0x3FB504F3.
REQ-036 The bench SHALL check: a=0x43000000 (128.0) -> c=0x7F800000 with overflow=1; a=0xC3000000 (-128.0) -> c=0x00000000 with underflow=1.
REQ-037 The bench SHALL check: a=0x7FC00001 -> c=0x7FC00000 with flags 0; a=0x00000001 (denormal) -> c=0x3F800000.
REQ-038 The bench SHALL check: 8 back-to-back operands, integers -3..4, -> 8 consecutive out_valid cycles, c in order 0x3E000000 ... 0x41800000.
REQ-039 The bench SHALL check: reset_n pulsed low while 2 operands are in flight -> no out_valid for them; c=0 and flags 0 during and after reset until a new operand completes.

Source files
------------

// File: rtl/single_pkg.sv
// Shared constants, operand classes and the 2^(j/32) fraction table
// for the single-precision base-2 power pipeline.
package single_pkg;

    localparam int          SINGLE_BIAS = 127;
    localparam logic [31:0] SINGLE_QNAN = 32'h7FC00000;
    localparam logic [31:0] SINGLE_PINF = 32'h7F800000;

    typedef enum logic [1:0] {
        CLS_NUM = 2'd0,
        CLS_NAN = 2'd1,
        CLS_OVF = 2'd2,
        CLS_UNF = 2'd3
    } cls_e;

    // Entry j holds round(2^(j/32) * 2^23) - 2^23; the last entry closes the octave.
    localparam logic [23:0] POW2_TABLE [0:32] = '{
        24'd0,       24'd183687,  24'd371395,  24'd563215,
        24'd759234,  24'd959546,  24'd1164243, 24'd1373424,
        24'd1587184, 24'd1805626, 24'd2028850, 24'd2256963,
        24'd2490071, 24'd2728283, 24'd2971711, 24'd3220470,
        24'd3474675, 24'd3734447, 24'd3999908, 24'd4271181,
        24'd4548394, 24'd4831678, 24'd5121164, 24'd5416990,
        24'd5719293, 24'd6028216, 24'd6343903, 24'd6666503,
        24'd6996167, 24'd7333050, 24'd7677309, 24'd8029107,
        24'd8388608
    };

endpackage

// File: rtl/single_to_fixed.sv
// Stage 1: classifies a single-precision operand and converts it to
// signed Q9.23, split into integer part n and fraction f.
module single_to_fixed
    import single_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        valid_i,
    input  logic [31:0] a_i,
    output logic        valid_o,
    output logic [1:0]  cls_o,
    output logic [8:0]  n_o,
    output logic [22:0] f_o
);

    logic        signBit;
    logic [7:0]  expField;
    logic [22:0] fracField;
    logic [30:0] magnitude_d;
    logic [31:0] fixed_d;
    cls_e        cls_d;

    logic        valid_q;
    cls_e        cls_q;
    logic [8:0]  n_q;
    logic [22:0] f_q;

    assign signBit   = a_i[31];
    assign expField  = a_i[30:23];
    assign fracField = a_i[22:0];

    // Range flags look at the exact operand, so -126.5 underflows even
    // though its truncated fixed-point value would still be representable.
    always_comb begin
        magnitude_d = '0;
        cls_d       = CLS_NUM;
        if (expField == 8'hFF) begin
            if (fracField != 23'd0) begin
                cls_d = CLS_NAN;
            end else begin
                cls_d = signBit ? CLS_UNF : CLS_OVF;
            end
        end else if (expField != 8'd0) begin
            if (expField >= 8'd134) begin
                cls_d = signBit ? CLS_UNF : CLS_OVF;
            end else if (signBit && (expField == 8'd133) && (fracField > 23'h7C0000)) begin
                cls_d = CLS_UNF;
            end
            if (expField >= 8'd127) begin
                magnitude_d = {7'b0, 1'b1, fracField} << (expField - 8'd127);
            end else begin
                magnitude_d = {7'b0, 1'b1, fracField} >> (8'd127 - expField);
            end
        end
    end

    assign fixed_d = signBit ? (32'd0 - {1'b0, magnitude_d}) : {1'b0, magnitude_d};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_i;
        end
    end

    always_ff @(posedge clk) begin
        if (valid_i) begin
            cls_q <= cls_d;
            n_q   <= fixed_d[31:23];
            f_q   <= fixed_d[22:0];
        end
    end

    assign valid_o = valid_q;
    assign cls_o   = cls_q;
    assign n_o     = n_q;
    assign f_o     = f_q;

endmodule

// File: rtl/single_base2_pow.sv
// Three-stage 2^x for IEEE-754 single: fixed-point conversion, table
// interpolation of the fractional power, then exponent assembly.
module single_base2_pow
    import single_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    input  logic [31:0] a,
    output logic        out_valid,
    output logic [31:0] c,
    output logic        overflow,
    output logic        underflow
);

    logic        s1Valid;
    logic [1:0]  s1ClsRaw;
    logic [8:0]  s1N;
    logic [22:0] s1F;

    logic [5:0]  idxLo;
    logic [5:0]  idxHi;
    logic [23:0] tLo;
    logic [23:0] delta;
    logic [41:0] product;
    logic [23:0] interp;
    logic [22:0] mant_d;

    logic        s2Valid_q;
    cls_e        s2Cls_q;
    logic [8:0]  s2N_q;
    logic [22:0] s2Mant_q;

    logic [9:0]  biasedExp;
    logic [31:0] c_d;
    logic        ovf_d;
    logic        unf_d;

    logic        outValid_q;
    logic [31:0] c_q;
    logic        ovf_q;
    logic        unf_q;

    single_to_fixed u_stage1 (
        .clk     (clk),
        .reset_n (reset_n),
        .valid_i (in_valid),
        .a_i     (a),
        .valid_o (s1Valid),
        .cls_o   (s1ClsRaw),
        .n_o     (s1N),
        .f_o     (s1F)
    );

    // The top five fraction bits pick a table segment, the low 18 bits
    // interpolate linearly inside it.
    assign idxLo   = {1'b0, s1F[22:18]};
    assign idxHi   = idxLo + 6'd1;
    assign tLo     = POW2_TABLE[idxLo];
    assign delta   = POW2_TABLE[idxHi] - tLo;
    assign product = 42'(delta) * 42'(s1F[17:0]);
    assign interp  = 24'(product >> 18);
    assign mant_d  = 23'(tLo + interp);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2Valid_q <= 1'b0;
        end else begin
            s2Valid_q <= s1Valid;
        end
    end

    always_ff @(posedge clk) begin
        if (s1Valid) begin
            s2Cls_q  <= cls_e'(s1ClsRaw);
            s2N_q    <= s1N;
            s2Mant_q <= mant_d;
        end
    end

    assign biasedExp = {s2N_q[8], s2N_q} + 10'(SINGLE_BIAS);

    always_comb begin
        c_d   = 32'd0;
        ovf_d = 1'b0;
        unf_d = 1'b0;
        case (s2Cls_q)
            CLS_NAN: c_d = SINGLE_QNAN;
            CLS_OVF: begin
                c_d   = SINGLE_PINF;
                ovf_d = 1'b1;
            end
            CLS_UNF: unf_d = 1'b1;
            default: begin
                if (biasedExp[9] || (biasedExp == 10'd0)) begin
                    unf_d = 1'b1;
                end else if (biasedExp >= 10'd255) begin
                    c_d   = SINGLE_PINF;
                    ovf_d = 1'b1;
                end else begin
                    c_d = {1'b0, biasedExp[7:0], s2Mant_q};
                end
            end
        endcase
    end

    // Result registers only move when a result lands, so idle cycles
    // keep presenting the last answer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            outValid_q <= 1'b0;
            c_q        <= 32'd0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            outValid_q <= s2Valid_q;
            if (s2Valid_q) begin
                c_q   <= c_d;
                ovf_q <= ovf_d;
                unf_q <= unf_d;
            end
        end
    end

    assign out_valid = outValid_q;
    assign c         = c_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule
